// File: rtl/vec_result_packer.sv
// rtl/vec_result_packer.sv - packs PE result elements into 32-bit VRF write words
// Optional feature macro: PACKER_MASK_EN (adds pe_mask_i, a per-element write mask)
module vec_result_packer #(
  parameter int VLEN   = 128,
  parameter int MAX_VL = 64,
  localparam int WPR   = VLEN / 32,
  localparam int VL_W  = $clog2(MAX_VL) + 1,
  localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [VL_W-1:0] vl_i,
  input  logic [1:0]      res_eew_i,
  input  logic [4:0]      vd_i,
  input  logic            pe_valid_i,
  output logic            pe_ready_o,
  input  logic [31:0]     pe_data_i,
`ifdef PACKER_MASK_EN
  input  logic            pe_mask_i,
`endif
  output logic            wr_en_o,
  input  logic            wr_ready_i,
  output logic [4:0]      wr_reg_o,
  output logic [WW-1:0]   wr_word_o,
  output logic [31:0]     wr_data_o,
  output logic [3:0]      wr_be_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t          state_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] cnt_q;
  logic [1:0]      eew_q;
  logic [4:0]      vd_q;
  logic [31:0]     acc_data_q;
  logic [3:0]      acc_be_q;
  logic            wr_en_q;
  logic [4:0]      wr_reg_q;
  logic [WW-1:0]   wr_word_q;
  logic [31:0]     wr_data_q;
  logic [3:0]      wr_be_q;
  logic            done_q;

  logic            elem_en;
  logic [1:0]      lane_mask;
  logic [1:0]      lane;
  logic [1:0]      byte_off;
  logic [VL_W-1:0] word_idx;
  logic [31:0]     elem_data;
  logic [31:0]     elem_data_d;
  logic [3:0]      elem_be;
  logic [3:0]      elem_be_d;
  logic            last_lane;
  logic            last_elem;
  logic            accept;
  logic            wr_hs;

`ifdef PACKER_MASK_EN
  assign elem_en = pe_mask_i;
`else
  assign elem_en = 1'b1;
`endif

  // Place the element at the current count into its lane and word
  always_comb begin
    lane_mask = 2'd0;
    elem_data = pe_data_i;
    elem_be   = 4'b1111;
    word_idx  = cnt_q;
    case (eew_q)
      2'd0: begin
        lane_mask = 2'd3;
        elem_data = {24'd0, pe_data_i[7:0]};
        elem_be   = 4'b0001;
        word_idx  = cnt_q >> 2;
      end
      2'd1: begin
        lane_mask = 2'd1;
        elem_data = {16'd0, pe_data_i[15:0]};
        elem_be   = 4'b0011;
        word_idx  = cnt_q >> 1;
      end
      default: begin
        lane_mask = 2'd0;
        elem_data = pe_data_i;
        elem_be   = 4'b1111;
        word_idx  = cnt_q;
      end
    endcase
    lane        = cnt_q[1:0] & lane_mask;
    byte_off    = lane << eew_q;
    elem_data_d = elem_data << {byte_off, 3'b000};
    elem_be_d   = elem_en ? (elem_be << byte_off) : 4'b0000;
    last_lane   = (lane == lane_mask);
    last_elem   = (cnt_q == vl_q - VL_W'(1));
  end

  assign pe_ready_o = (state_q == PACK) && (!wr_en_q || wr_ready_i);
  assign accept     = pe_valid_i && pe_ready_o;
  assign wr_hs      = wr_en_q && wr_ready_i;

  // Control FSM, accumulator and registered write port
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      vl_q       <= '0;
      cnt_q      <= '0;
      eew_q      <= 2'd0;
      vd_q       <= 5'd0;
      acc_data_q <= 32'd0;
      acc_be_q   <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= 5'd0;
      wr_word_q  <= '0;
      wr_data_q  <= 32'd0;
      wr_be_q    <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            vl_q       <= vl_i;
            eew_q      <= (res_eew_i == 2'd3) ? 2'd2 : res_eew_i;
            vd_q       <= vd_i;
            cnt_q      <= '0;
            acc_data_q <= 32'd0;
            acc_be_q   <= 4'd0;
            if (vl_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= PACK;
            end
          end
        end
        PACK: begin
          if (accept) begin
            cnt_q <= cnt_q + VL_W'(1);
            if (last_lane || last_elem) begin
              // Completed word replaces whatever sat in the output register
              wr_en_q    <= 1'b1;
              wr_data_q  <= acc_data_q | elem_data_d;
              wr_be_q    <= acc_be_q | elem_be_d;
              wr_reg_q   <= vd_q + 5'(word_idx / WPR);
              wr_word_q  <= WW'(word_idx % WPR);
              acc_data_q <= 32'd0;
              acc_be_q   <= 4'd0;
            end else begin
              acc_data_q <= acc_data_q | elem_data_d;
              acc_be_q   <= acc_be_q | elem_be_d;
              if (wr_hs) begin
                wr_en_q <= 1'b0;
              end
            end
            if (last_elem) begin
              state_q <= DRAIN;
            end
          end else if (wr_hs) begin
            wr_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (wr_hs) begin
            wr_en_q <= 1'b0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_reg_o  = wr_reg_q;
  assign wr_word_o = wr_word_q;
  assign wr_data_o = wr_data_q;
  assign wr_be_o   = wr_be_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule
